// File: rtl/input_cond_pkg.sv
// input_cond_pkg: shared debounce state encoding and channel limit for the input conditioner.
package input_cond_pkg;
  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} debounce_state_t;
  localparam int MaxChannels = 8;
endpackage

// File: rtl/input_conditioner_channel.sv
// debounce_channel: one input channel - 2-flop sync, debounce FSM, press/release pulses, toggle.
// Auto-repeat of o_press while held is compiled in only when INPUT_AUTOREPEAT_EN is defined.
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int DebounceCycles = 500000
`ifdef INPUT_AUTOREPEAT_EN
  ,
  parameter int RepeatDelay = 25000000,
  parameter int RepeatPeriod = 5000000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic toggle_o
);
  localparam int CntW = $clog2(DebounceCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);
  logic [1:0] sync_q;
  logic [CntW-1:0] cnt_q;
  debounce_state_t state_q;
  logic level_q, press_q, release_q, toggle_q;
`ifdef INPUT_AUTOREPEAT_EN
  localparam int RepMax = (RepeatDelay > RepeatPeriod) ? RepeatDelay : RepeatPeriod;
  localparam int RepW = (RepMax > 1) ? $clog2(RepMax) : 1;
  localparam logic [RepW-1:0] RepDly = RepW'(RepeatDelay - 1);
  localparam logic [RepW-1:0] RepPer = RepW'(RepeatPeriod - 1);
  logic [RepW-1:0] rep_q;
  logic rpt_q;
`endif
  // sync_q[1] is the synchronized sample the FSM acts on
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      state_q   <= RELEASED;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
`ifdef INPUT_AUTOREPEAT_EN
      rep_q     <= '0;
      rpt_q     <= 1'b0;
`endif
    end else begin
      sync_q    <= {sync_q[0], in_i};
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        RELEASED: begin
          if (sync_q[1]) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync_q[1]) state_q <= RELEASED;
          else if (cnt_q == CntMax) begin
            state_q  <= PRESSED;
            level_q  <= 1'b1;
            press_q  <= 1'b1;
            toggle_q <= ~toggle_q;
`ifdef INPUT_AUTOREPEAT_EN
            rep_q    <= '0;
            rpt_q    <= 1'b0;
`endif
          end else cnt_q <= cnt_q + 1'b1;
        end
        PRESSED: begin
          if (!sync_q[1]) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end
`ifdef INPUT_AUTOREPEAT_EN
          else if (rep_q == (rpt_q ? RepPer : RepDly)) begin
            press_q <= 1'b1;
            rep_q   <= '0;
            rpt_q   <= 1'b1;
          end else rep_q <= rep_q + 1'b1;
`endif
        end
        RELEASE_WAIT: begin
          if (sync_q[1]) begin
            state_q <= PRESSED;
`ifdef INPUT_AUTOREPEAT_EN
            rep_q   <= '0;
            rpt_q   <= 1'b0;
`endif
          end else if (cnt_q == CntMax) begin
            state_q   <= RELEASED;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else cnt_q <= cnt_q + 1'b1;
        end
        default: state_q <= RELEASED;
      endcase
    end
  end
  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign toggle_o  = toggle_q;
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: polarity fix-up and packing of per-channel debouncers for board keys.
// Optional auto-repeat via INPUT_AUTOREPEAT_EN.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int Channels = 4,
  parameter bit ActiveLow = 1'b1,
  parameter int DebounceCycles = 500000,
  parameter int RepeatDelay = 25000000,
  parameter int RepeatPeriod = 5000000
) (
  input  logic                i_clock_50mhz,
  input  logic                i_reset,
  input  logic [Channels-1:0] i_pins,
  output logic [Channels-1:0] o_level,
  output logic [Channels-1:0] o_press,
  output logic [Channels-1:0] o_release,
  output logic [Channels-1:0] o_toggle
);
  if (Channels < 1 || Channels > MaxChannels || DebounceCycles < 2 || RepeatDelay < 1 ||
      RepeatPeriod < 1) begin : g_bad_params
    $error("input_conditioner: parameter out of range");
  end
  logic [Channels-1:0] pressed_raw;
  assign pressed_raw = i_pins ^ {Channels{ActiveLow}};
  for (genvar g = 0; g < Channels; g++) begin : g_ch
    debounce_channel #(
      .DebounceCycles(DebounceCycles)
`ifdef INPUT_AUTOREPEAT_EN
      ,
      .RepeatDelay(RepeatDelay),
      .RepeatPeriod(RepeatPeriod)
`endif
    ) u_ch (
      .clk      (i_clock_50mhz),
      .rst      (i_reset),
      .in_i     (pressed_raw[g]),
      .level_o  (o_level[g]),
      .press_o  (o_press[g]),
      .release_o(o_release[g]),
      .toggle_o (o_toggle[g])
    );
  end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed stimulus with a run-length debounce model checked every cycle.
module tb_input_conditioner;
  localparam int N = 4;
  localparam int D = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] pins;
  logic [N-1:0] o_level, o_press, o_release, o_toggle;
  int checks = 0;
  int failures = 0;
  int press_cnt [N];
  int base3;
  bit live = 1'b0;
  logic [N-1:0] m_lvl, m_tog, m_prs, m_rel;
  bit p1 [N];
  bit p2 [N];
  int run [N];
  int h [N];

  always #5 clk = ~clk;

  input_conditioner #(
    .Channels(N), .ActiveLow(1'b1), .DebounceCycles(D), .RepeatDelay(RD), .RepeatPeriod(RP)
  ) dut (
    .i_clock_50mhz(clk), .i_reset(rst), .i_pins(pins),
    .o_level(o_level), .o_press(o_press), .o_release(o_release), .o_toggle(o_toggle)
  );

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", n, got, exp, $time);
    end
  endtask

  // model: a level change is accepted once the synchronized input has disagreed with the
  // accepted level for D+1 consecutive samples
  always @(posedge clk) begin
    bit obs;
    live = 1'b1;
    for (int c = 0; c < N; c++) begin
      if (rst) begin
        p1[c] = 0; p2[c] = 0; run[c] = 0; h[c] = 0;
        m_lvl[c] = 0; m_tog[c] = 0; m_prs[c] = 0; m_rel[c] = 0;
      end else begin
        obs = p2[c];
        p2[c] = p1[c];
        p1[c] = ~pins[c];
        m_prs[c] = 0;
        m_rel[c] = 0;
`ifdef INPUT_AUTOREPEAT_EN
        if (m_lvl[c] && obs) begin
          if (run[c] != 0) h[c] = 0;
          else begin
            h[c]++;
            if (h[c] == RD || (h[c] > RD && (h[c] - RD) % RP == 0)) m_prs[c] = 1;
          end
        end
`endif
        run[c] = (obs != m_lvl[c]) ? run[c] + 1 : 0;
        if (run[c] == D + 1) begin
          m_lvl[c] = obs;
          run[c] = 0;
          if (obs) begin
            m_prs[c] = 1; m_tog[c] = ~m_tog[c]; h[c] = 0;
          end else m_rel[c] = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("model_level", o_level, m_lvl);
      chk("model_press", o_press, m_prs);
      chk("model_release", o_release, m_rel);
      chk("model_toggle", o_toggle, m_tog);
      for (int c = 0; c < N; c++) press_cnt[c] += int'(o_press[c]);
    end
  end

  initial begin
    for (int c = 0; c < N; c++) press_cnt[c] = 0;
    pins = '1;
    rst = 1'b1;
    // 1: reset with all keys released
    repeat (10) begin
      @(posedge clk); #1;
      chk("rst_outputs", {o_level, o_press, o_release, o_toggle}, 0);
    end
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    // 2: clean press/release of ch0
    @(negedge clk) pins[0] = 1'b0;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 chk("t2_level_k5", o_level[0], 0);
    @(posedge clk); #1;
    chk("t2_level_k6", o_level[0], 1);
    chk("t2_press_k6", o_press[0], 1);
    chk("t2_toggle", o_toggle[0], 1);
    @(posedge clk); #1;
    chk("t2_press_k7", o_press[0], 0);
    @(negedge clk) pins[0] = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 chk("t2_release_k5", o_release[0], 0);
    @(posedge clk); #1;
    chk("t2_release_k6", o_release[0], 1);
    chk("t2_level_off", o_level[0], 0);
    chk("t2_toggle_held", o_toggle[0], 1);
    // 3: ch1 bounce shorter than the debounce window
    @(negedge clk) pins[1] = 1'b0;
    repeat (3) @(negedge clk);
    pins[1] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t3_no_press", press_cnt[1], 0);
    chk("t3_no_level", o_level[1], 0);
    // 4: simultaneous press of ch0 and ch2
    @(negedge clk) pins = 4'b1010;
    @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    chk("t4_press", o_press, 4'b0101);
    chk("t4_toggle", o_toggle, 4'b0100);
    @(negedge clk) pins = '1;
    repeat (10) @(posedge clk);
    // 5: reset in the middle of ch0 debounce with key still held
    @(negedge clk) pins[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("t5_rst_outputs", {o_level, o_press, o_release, o_toggle}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("t5_level_early", o_level[0], 0);
    @(posedge clk); #1;
    chk("t5_level", o_level[0], 1);
    chk("t5_press", o_press[0], 1);
    chk("t5_toggle", o_toggle[0], 1);
    @(negedge clk) pins = '1;
    repeat (10) @(posedge clk);
    // 6: ch3 held 30 cycles
    @(negedge clk);
    base3 = press_cnt[3];
    pins[3] = 1'b0;
    repeat (30) @(negedge clk);
    pins[3] = 1'b1;
    repeat (12) @(posedge clk);
    #1;
`ifdef INPUT_AUTOREPEAT_EN
    chk("t6_press_count", press_cnt[3] - base3, 7);
`else
    chk("t6_press_count", press_cnt[3] - base3, 1);
`endif
    chk("t6_toggle", o_toggle[3], 1);
    chk("t6_level_off", o_level[3], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
